debug_trace_buffer: RTL
=======================

// Module: debug_trace_buffer
// PURPOSE
//  Parametrised on-chip trace capture for the pipelined MIPS debug probes (debug_N, PC, regs).
//  Samples NUM_CH channels of DATA_W bits into a circular buffer with pre-/post-trigger windows.
//  Freezes on completion and exposes a random-access, trigger-relative readout port.
//  Replaces watching raw debug wires in simulation; synthesisable for FPGA bring-up.
// PARAMETERS
//  NUM_CH    9   number of probed channels
//  DATA_W    32  bits per channel
//  DEPTH     16  entries in buffer; power of 2, >= 2
//  PRE_TRIG  4   samples kept before trigger; 0 <= PRE_TRIG < DEPTH
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 asynchronous, active-low reset
//  arm        in   1                 pulse: start new capture (IDLE or DONE only)
//  abort      in   1                 pulse: return to IDLE from any state
//  sample_en  in   1                 qualifies ch_data this cycle
//  ch_data    in   NUM_CH*DATA_W     channel k at [k*DATA_W +: DATA_W]
//  trig_sel   in   $clog2(NUM_CH)    channel compared for trigger
//  trig_val   in   DATA_W            trigger match value
//  trig_mask  in   DATA_W            1 = bit compared; all-0 mask triggers on first ARMED sample
//  rd_addr    in   $clog2(DEPTH)     readout index, 0 = oldest captured sample
//  rd_data    out  NUM_CH*DATA_W     registered readout, 1-cycle latency
//  state      out  3                 0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 DONE
//  done       out  1                 high in DONE
//  trig_seen  out  1                 high in POST and DONE
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, count=0, trig_ptr=0, remaining=0, rd_data=0, done=0.
//    Buffer RAM is not cleared. Reset mid-capture discards the capture.
//  Write: in FILL/ARMED/POST, sample_en=1 writes ch_data to mem[wr_ptr]; wr_ptr wraps mod DEPTH.
//    count saturates at DEPTH.
//  IDLE: arm -> FILL, wr_ptr=0, count=0.
//  FILL: writes; once count == PRE_TRIG after the write -> ARMED.
//    With PRE_TRIG=0, go directly from IDLE to ARMED. Triggers in FILL are ignored.
//  ARMED: trigger = sample_en & ((ch[trig_sel] ^ trig_val) & trig_mask) == 0.
//    On trigger, write the sample, trig_ptr=wr_ptr, remaining=DEPTH-PRE_TRIG-1.
//    Go POST, or DONE if remaining==0. Buffer may wrap many times in ARMED.
//  POST: each sample_en write decrements remaining; the write taking it to 0 -> DONE.
//  DONE: no writes. arm -> FILL (new capture), abort -> IDLE.
//    arm in FILL/ARMED/POST is ignored.
//  abort has priority over arm and trigger in the same cycle; sample in that cycle not written.
//  Readout: rd_data <= mem[(trig_ptr - PRE_TRIG + rd_addr) mod DEPTH], every cycle.
//    Valid when done=1. rd_addr==PRE_TRIG returns the trigger sample.
//  Write and read of the same entry in one cycle: read returns old contents (no bypass).
//  trig_sel >= NUM_CH: never triggers.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: extra port rd_ts out 16.
//    A free-running 16-bit cycle counter (reset 0, wraps) is stored with each written entry.
//    rd_ts is read alongside rd_data with the same latency; reset value 0.
//  Not defined: no counter, no rd_ts port, no timestamp storage.
// TESTING
//  (bench: NUM_CH=2, DATA_W=8, DEPTH=16, PRE_TRIG=4; ch0 = sample count n, ch1 = ~n)
//  1 Basic: arm, sample_en=1 always, trig ch0==20, mask FF -> done after n=31.
//    rd_addr 0..15 returns ch0 16..31; rd_addr 4 gives ch0=20, ch1=EB.
//  2 Trigger during FILL: trig ch0==2 -> ignored. Match at n=2+256 -> rd_addr 4 = 02, rd_addr 0 = FE.
//  3 Gaps: sample_en toggles 1,0 -> only enabled samples stored; done after 11 enabled post-trigger samples.
//  4 Abort: abort in POST -> state=0 next cycle, done=0. Simultaneous arm+abort in DONE -> IDLE.
//  5 Reset: rst=0 in POST -> state=0, done=0, rd_data=0 immediately, without waiting for clk.
//  6 TRACE_TIMESTAMP_EN: ts reset at start of test 1.
//    rd_ts at rd_addr 0 = 16+arm offset; consecutive entries differ by 1.

Source files
------------

// File: rtl/debug_trace_buffer.sv
// Trace capture into a circular buffer with pre/post-trigger windows and trigger-relative readout.
// Optional TRACE_TIMESTAMP_EN adds a 16-bit cycle timestamp per entry on port rd_ts.
module debug_trace_buffer #(
  parameter int unsigned NUM_CH   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PRE_TRIG = 4,
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     sample_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         trig_sel,
  input  logic [DATA_W-1:0]        trig_val,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [AW-1:0]            rd_addr,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [2:0]               state,
  output logic                     done,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]              rd_ts,
`endif
  output logic                     trig_seen
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRE_C    = (AW+1)'(PRE_TRIG);
  localparam logic [AW:0] REM_INIT = (AW+1)'(DEPTH - PRE_TRIG - 1);
  localparam state_e      ARM_DEST = (PRE_TRIG == 0) ? S_ARMED : S_FILL;

  state_e                     state_q, state_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW:0]                count_q, count_d;
  logic [AW-1:0]              trig_ptr_q, trig_ptr_d;
  logic [AW:0]                remaining_q, remaining_d;
  logic [NUM_CH*DATA_W-1:0]   rd_data_q;
  logic [NUM_CH*DATA_W-1:0]   mem [DEPTH];

  logic                       wr_en;
  logic [AW:0]                count_inc;
  logic [DATA_W-1:0]          trig_ch;
  logic                       sel_hit;
  logic                       trig_hit;
  logic [AW-1:0]              rd_idx;

  // Out-of-range trig_sel leaves sel_hit low, so it can never trigger.
  always_comb begin
    trig_ch = '0;
    sel_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (trig_sel == SEL_W'(k)) begin
        trig_ch = ch_data[k*DATA_W +: DATA_W];
        sel_hit = 1'b1;
      end
    end
  end

  assign trig_hit  = sample_en & sel_hit & (((trig_ch ^ trig_val) & trig_mask) == '0);
  assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trig_ptr_d  = trig_ptr_q;
    remaining_d = remaining_q;
    wr_en       = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d  = ARM_DEST;
            wr_ptr_d = '0;
            count_d  = '0;
          end
        end
        S_FILL: begin
          if (sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_inc;
            if (count_inc == PRE_C) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_inc;
            if (trig_hit) begin
              trig_ptr_d  = wr_ptr_q;
              remaining_d = REM_INIT;
              state_d     = (REM_INIT == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_en) begin
            wr_en       = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            count_d     = count_inc;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == (AW+1)'(1)) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_ptr_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trig_ptr_q  <= trig_ptr_d;
      remaining_q <= remaining_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= ch_data;
  end

  // Index arithmetic is AW bits wide, so the modulo-DEPTH wrap is implicit.
  assign rd_idx = trig_ptr_q - AW'(PRE_TRIG) + rd_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= mem[rd_idx];
  end

  assign rd_data   = rd_data_q;
  assign state     = state_q;
  assign done      = (state_q == S_DONE);
  assign trig_seen = (state_q == S_POST) || (state_q == S_DONE);

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] rd_ts_q;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_ts_q <= '0;
    else      rd_ts_q <= ts_mem[rd_idx];
  end

  assign rd_ts = rd_ts_q;
`endif

endmodule
